mac_4bit_vec_seq: RTL and testbench
===================================

Name: mac_4bit_vec_seq

Overview:
Upstream sequencer for the 4-bit MAC slice in the eFPGA math block. Accepts a valid/ready stream of 4-bit operand/coefficient pairs that form one dot-product vector, drives the MAC control/data inputs cycle by cycle, and captures the MAC's 4-bit output once the vector completes. Presents the result on a valid/ready result port. Owns the accumulator clear/round, clock-enable and output-select control of the MAC.

Parameters:
MAX_LEN, 16, maximum beats per vector; reaching it without IN_LAST forces vector end.
CNT_W, 5, beat counter width; must hold MAX_LEN.

Ports:
MAC_ACC_CLK  input  1  clock, shared with the MAC accumulator.
MAC_ACC_RST  input  1  synchronous active-high reset.
IN_VALID  input  1  beat valid.
IN_READY  output  1  beat accept; high only in RUN.
IN_OPER  input  4  operand nibble.
IN_COEF  input  4  coefficient nibble.
IN_LAST  input  1  final beat of vector.
CFG_OUT_SEL  input  6  output bit-select, sampled on first beat.
CFG_SAT  input  1  saturation enable, sampled on first beat.
CFG_TC  input  1  two's-complement mode, sampled on first beat.
CFG_RND  input  1  round-to-nearest enable, sampled on first beat.
MAC_OPER_DATA  output  4  to MAC operand.
MAC_COEF_DATA  output  4  to MAC coefficient.
EFPGA_MATHB_CLK_EN  output  1  MAC accumulator load enable.
MAC_ACC_CLEAR  output  1  zero feedback on first beat.
MAC_ACC_RND  output  1  rounding-constant feedback on first beat.
MAC_OUT_SEL  output  6  latched CFG_OUT_SEL.
MAC_ACC_SAT  output  1  latched CFG_SAT.
MAC_TC  output  1  latched CFG_TC.
MAC_OUT  input  4  MAC result, combinational from its accumulator.
RES_VALID  output  1  result valid.
RES_READY  input  1  result accept.
RES_DATA  output  4  captured MAC_OUT.
RES_CNT  output  CNT_W  beats in vector.
RES_OVF  output  1  vector ended by MAX_LEN, not IN_LAST.

Behaviour:
- Reset applies to all outputs: every output is 0; state RUN; first-beat flag set. IN_READY rises the cycle after reset deasserts. The MAC accumulator is not reset by this block. Correctness relies on the first beat always selecting CLEAR or RND feedback.
- FSM states: RUN, WAIT, CAP, HOLD.
- RUN: IN_READY=1. On handshake (IN_VALID&IN_READY):
  - Register IN_OPER/IN_COEF to MAC_OPER_DATA/MAC_COEF_DATA.
  - EFPGA_MATHB_CLK_EN<=1 for the next cycle.
  - Beat count increments.
- First beat of a vector:
  - Latch the CFG_* inputs to MAC_OUT_SEL/MAC_ACC_SAT/MAC_TC. These are held stable until the next vector's first beat.
  - Drive MAC_ACC_RND<=CFG_RND and MAC_ACC_CLEAR<=~CFG_RND for that one drive cycle.
- Later beats drive CLEAR=RND=0. Cycles in RUN without a handshake drive EFPGA_MATHB_CLK_EN=0, so the accumulator holds.
- Vector end: IN_LAST on the handshake, or beat count reaching MAX_LEN on the handshake (RES_OVF<=1 unless IN_LAST was also set). On vector end: RUN->WAIT.
- WAIT (last beat's drive cycle; the MAC accumulates at its end): IN_READY=0 -> CAP.
- CAP: MAC_OUT reflects the final accumulator; EFPGA_MATHB_CLK_EN=0. At the end of CAP, RES_DATA<=MAC_OUT, RES_CNT<=count, RES_VALID<=1 -> HOLD.
- Latency: RES_VALID is high 2 cycles after the last-beat handshake edge.
- HOLD: RES_VALID=1; RES_DATA/RES_CNT/RES_OVF stable. On RES_READY: RES_VALID<=0, count<=0, first flag<=1, RES_OVF cleared -> RUN.
- Throughput: 1 beat/cycle within a vector; minimum 3 non-accepting cycles between vectors.
- Single-beat vector: first and last coincide; CLEAR/RND and data occupy the same drive cycle.
- CFG_* changes mid-vector are ignored.
- IN_VALID while not in RUN: no effect; the beat is held upstream.
- Reset mid-operation (any state): returns to reset values the next cycle. Any partial or pending result is discarded and no RES_VALID is produced.

Test Plan:
1. Unsigned, CFG_OUT_SEL=0, CFG_SAT=0: beats (3,5),(2,7,last) -> RES_DATA=0xD, RES_CNT=2, RES_OVF=0, RES_VALID 2 cycles after last handshake. Same vector with CFG_SAT=1 -> RES_DATA=0xF.
2. CFG_TC=1, CFG_SAT=1: beats (0xE,3),(1,1,last) -> sum -5, RES_DATA=0xB. Single beat (7,7,last) -> RES_DATA=0x7 (positive saturation).
3. CFG_OUT_SEL=2: beats (3,3),(1,1,last) with CFG_RND=0 -> RES_DATA=2; with CFG_RND=1 -> RES_DATA=3. Check RND/CLEAR pulse only in the first drive cycle.
4. 16 beats of (1,1), no IN_LAST -> forced end, RES_CNT=16, RES_OVF=1, RES_DATA=0 (sum 16, bits[3:0]=0, SAT off).
5. RES_READY held low 5 cycles -> RES_VALID/RES_DATA stable, IN_READY=0, IN_VALID ignored. Next vector (2,2,last) after a 0x0F vector -> RES_DATA=4; this checks the first-beat clear.
6. Assert MAC_ACC_RST in WAIT -> no RES_VALID. Next vector (1,3,last) -> RES_DATA=3 and all outputs 0 during reset.

Source files
------------

// File: rtl/mac_4bit_vec_seq.sv
// Upstream sequencer for the 4-bit MAC slice in the eFPGA math block.
// Accepts a valid/ready stream of operand/coefficient beats that form one dot-product vector.
// Drives the MAC control and data cycle by cycle, then captures the MAC result.
// The result is presented on a valid/ready port.
module mac_4bit_vec_seq #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5
) (
   input  logic             MAC_ACC_CLK,
   input  logic             MAC_ACC_RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [3:0]       IN_OPER,
   input  logic [3:0]       IN_COEF,
   input  logic             IN_LAST,
   input  logic [5:0]       CFG_OUT_SEL,
   input  logic             CFG_SAT,
   input  logic             CFG_TC,
   input  logic             CFG_RND,
   output logic [3:0]       MAC_OPER_DATA,
   output logic [3:0]       MAC_COEF_DATA,
   output logic             EFPGA_MATHB_CLK_EN,
   output logic             MAC_ACC_CLEAR,
   output logic             MAC_ACC_RND,
   output logic [5:0]       MAC_OUT_SEL,
   output logic             MAC_ACC_SAT,
   output logic             MAC_TC,
   input  logic [3:0]       MAC_OUT,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [3:0]       RES_DATA,
   output logic [CNT_W-1:0] RES_CNT,
   output logic             RES_OVF
);

   // RUN accepts beats; WAIT is the last beat's drive cycle; CAP samples MAC_OUT; HOLD presents the result.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAP  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] count, count_nx, cnt_inc;
   logic             first, first_nx;
   logic             handshake;
   logic             ready_nx;
   logic [3:0]       oper_nx, coef_nx;
   logic             en_nx, clr_nx, rnd_nx;
   logic [5:0]       sel_nx;
   logic             sat_nx, tc_nx;
   logic             res_valid_nx, ovf_nx;
   logic [3:0]       res_data_nx;
   logic [CNT_W-1:0] res_cnt_nx;

   assign handshake = IN_VALID & IN_READY;
   assign cnt_inc   = count + {{(CNT_W-1){1'b0}}, 1'b1};

   // Next-state and next-output logic; every registered output holds unless a state acts on it.
   always_comb begin
      state_nx     = state;
      count_nx     = count;
      first_nx     = first;
      oper_nx      = MAC_OPER_DATA;
      coef_nx      = MAC_COEF_DATA;
      en_nx        = 1'b0;
      clr_nx       = 1'b0;
      rnd_nx       = 1'b0;
      sel_nx       = MAC_OUT_SEL;
      sat_nx       = MAC_ACC_SAT;
      tc_nx        = MAC_TC;
      res_valid_nx = RES_VALID;
      res_data_nx  = RES_DATA;
      res_cnt_nx   = RES_CNT;
      ovf_nx       = RES_OVF;
      case (state)
         ST_RUN: begin
            if (handshake) begin
               oper_nx  = IN_OPER;
               coef_nx  = IN_COEF;
               en_nx    = 1'b1;
               count_nx = cnt_inc;
               first_nx = 1'b0;
               // The first beat must select CLEAR or RND feedback: the MAC accumulator is never reset here.
               if (first) begin
                  sel_nx = CFG_OUT_SEL;
                  sat_nx = CFG_SAT;
                  tc_nx  = CFG_TC;
                  clr_nx = ~CFG_RND;
                  rnd_nx = CFG_RND;
               end else begin
                  clr_nx = 1'b0;
                  rnd_nx = 1'b0;
               end
               if (IN_LAST || (cnt_inc == CNT_W'(MAX_LEN))) begin
                  state_nx = ST_WAIT;
                  ovf_nx   = ~IN_LAST;
               end else begin
                  state_nx = ST_RUN;
               end
            end else begin
               en_nx = 1'b0;
            end
         end
         ST_WAIT: begin
            state_nx = ST_CAP;
         end
         ST_CAP: begin
            res_data_nx  = MAC_OUT;
            res_cnt_nx   = count;
            res_valid_nx = 1'b1;
            state_nx     = ST_HOLD;
         end
         ST_HOLD: begin
            if (RES_READY) begin
               res_valid_nx = 1'b0;
               count_nx     = {CNT_W{1'b0}};
               first_nx     = 1'b1;
               ovf_nx       = 1'b0;
               state_nx     = ST_RUN;
            end else begin
               state_nx = ST_HOLD;
            end
         end
         default: begin
            state_nx = ST_RUN;
         end
      endcase
      ready_nx = (state_nx == ST_RUN);
   end

   // State and output registers; synchronous reset clears every output and re-arms the first-beat flag.
   always_ff @(posedge MAC_ACC_CLK) begin
      if (MAC_ACC_RST) begin
         state              <= ST_RUN;
         count              <= {CNT_W{1'b0}};
         first              <= 1'b1;
         IN_READY           <= 1'b0;
         MAC_OPER_DATA      <= 4'h0;
         MAC_COEF_DATA      <= 4'h0;
         EFPGA_MATHB_CLK_EN <= 1'b0;
         MAC_ACC_CLEAR      <= 1'b0;
         MAC_ACC_RND        <= 1'b0;
         MAC_OUT_SEL        <= 6'h00;
         MAC_ACC_SAT        <= 1'b0;
         MAC_TC             <= 1'b0;
         RES_VALID          <= 1'b0;
         RES_DATA           <= 4'h0;
         RES_CNT            <= {CNT_W{1'b0}};
         RES_OVF            <= 1'b0;
      end else begin
         state              <= state_nx;
         count              <= count_nx;
         first              <= first_nx;
         IN_READY           <= ready_nx;
         MAC_OPER_DATA      <= oper_nx;
         MAC_COEF_DATA      <= coef_nx;
         EFPGA_MATHB_CLK_EN <= en_nx;
         MAC_ACC_CLEAR      <= clr_nx;
         MAC_ACC_RND        <= rnd_nx;
         MAC_OUT_SEL        <= sel_nx;
         MAC_ACC_SAT        <= sat_nx;
         MAC_TC             <= tc_nx;
         RES_VALID          <= res_valid_nx;
         RES_DATA           <= res_data_nx;
         RES_CNT            <= res_cnt_nx;
         RES_OVF            <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_mac_4bit_vec_seq.sv
// Testbench for mac_4bit_vec_seq: a behavioural 4-bit MAC slice closes the loop.
// Directed vectors with hand-computed results are applied from a table.
module tb_mac_4bit_vec_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_last;
   logic [3:0] in_oper, in_coef;
   logic [5:0] cfg_out_sel;
   logic       cfg_sat, cfg_tc, cfg_rnd;
   logic [3:0] mac_oper, mac_coef;
   logic       mac_en, mac_clr, mac_rnd;
   logic [5:0] mac_sel;
   logic       mac_sat, mac_tc;
   logic [3:0] mac_out;
   logic       res_valid, res_ready, res_ovf;
   logic [3:0] res_data;
   logic [4:0] res_cnt;

   int checks = 0;
   int errors = 0;

   mac_4bit_vec_seq #(.MAX_LEN(16), .CNT_W(5)) dut (
      .MAC_ACC_CLK(clk), .MAC_ACC_RST(rst),
      .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OPER(in_oper), .IN_COEF(in_coef), .IN_LAST(in_last),
      .CFG_OUT_SEL(cfg_out_sel), .CFG_SAT(cfg_sat), .CFG_TC(cfg_tc), .CFG_RND(cfg_rnd),
      .MAC_OPER_DATA(mac_oper), .MAC_COEF_DATA(mac_coef), .EFPGA_MATHB_CLK_EN(mac_en),
      .MAC_ACC_CLEAR(mac_clr), .MAC_ACC_RND(mac_rnd), .MAC_OUT_SEL(mac_sel),
      .MAC_ACC_SAT(mac_sat), .MAC_TC(mac_tc), .MAC_OUT(mac_out),
      .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data),
      .RES_CNT(res_cnt), .RES_OVF(res_ovf)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // ---------------- behavioural MAC slice ----------------
   int acc = 37;   // arbitrary power-up content: only the first-beat clear/round makes results correct

   function automatic int nib(input logic [3:0] x, input logic tc);
      nib = (tc && x[3]) ? int'(x) - 16 : int'(x);
   endfunction

   // Accumulator: loads feedback (zero, round constant or itself) plus the product when enabled.
   always @(posedge clk) begin
      int base;
      if (mac_clr)      base = 0;
      else if (mac_rnd) base = (mac_sel == 6'd0) ? 0 : (1 << (int'(mac_sel) - 1));
      else              base = acc;
      if (mac_en) acc <= base + nib(mac_oper, mac_tc) * nib(mac_coef, mac_tc);
   end

   // Output view: bit-select shift, optional saturation to the 4-bit range.
   always_comb begin
      int v;
      v = acc >>> mac_sel;
      if (mac_sat) begin
         if (mac_tc) begin
            if (v > 7) v = 7;
            else if (v < -8) v = -8;
         end else begin
            if (v > 15) v = 15;
            else if (v < 0) v = 0;
         end
      end
      mac_out = v[3:0];
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [30:0] all_outs();
      all_outs = {in_ready, mac_oper, mac_coef, mac_en, mac_clr, mac_rnd, mac_sel, mac_sat, mac_tc,
                  res_valid, res_data, res_cnt, res_ovf};
   endfunction

   typedef struct {
      logic [5:0]       sel;
      logic             sat, tc, rnd;
      int               n;
      logic [15:0][3:0] op;
      logic [15:0][3:0] cf;
      logic             last, hold, abort;
      logic [3:0]       exp_data;
      logic [4:0]       exp_cnt;
      logic             exp_ovf;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] sel, input logic sat, input logic tc, input logic rnd,
                               input int n, input logic [63:0] op, input logic [63:0] cf,
                               input logic last, input logic hold, input logic abort,
                               input logic [3:0] d, input logic [4:0] c, input logic o);
      mk.sel = sel; mk.sat = sat; mk.tc = tc; mk.rnd = rnd; mk.n = n;
      mk.op = op; mk.cf = cf; mk.last = last; mk.hold = hold; mk.abort = abort;
      mk.exp_data = d; mk.exp_cnt = c; mk.exp_ovf = o;
   endfunction

   vec_t tbl[12];

   // Drives all beats of vector v; returns at the negedge following the last handshake (WAIT cycle).
   task automatic drive_beats(input vec_t v);
      for (int b = 0; b < v.n; b++) begin
         int t;
         in_valid = 1'b1;
         in_oper  = v.op[b];
         in_coef  = v.cf[b];
         in_last  = (b == v.n - 1) ? v.last : 1'b0;
         if (b == 0) begin
            cfg_out_sel = v.sel; cfg_sat = v.sat; cfg_tc = v.tc; cfg_rnd = v.rnd;
         end else begin
            cfg_out_sel = ~v.sel; cfg_sat = ~v.sat; cfg_tc = ~v.tc; cfg_rnd = ~v.rnd;
         end
         t = 0;
         while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
         @(negedge clk);
         chk("drive_oper", {28'd0, mac_oper}, {28'd0, v.op[b]});
         chk("drive_coef", {28'd0, mac_coef}, {28'd0, v.cf[b]});
         chk("drive_en",   {31'd0, mac_en}, 32'd1);
         chk("drive_clear", {31'd0, mac_clr}, {31'd0, (b == 0) && !v.rnd});
         chk("drive_rnd",   {31'd0, mac_rnd}, {31'd0, (b == 0) && v.rnd});
         chk("cfg_latch", {24'd0, mac_sel, mac_sat, mac_tc}, {24'd0, v.sel, v.sat, v.tc});
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      tbl[0]  = mk(6'd0, 1'b0, 1'b0, 1'b0, 2,  64'h23, 64'h75, 1'b1, 1'b0, 1'b0, 4'hD, 5'd2, 1'b0);
      tbl[1]  = mk(6'd0, 1'b1, 1'b0, 1'b0, 2,  64'h23, 64'h75, 1'b1, 1'b0, 1'b0, 4'hF, 5'd2, 1'b0);
      tbl[2]  = mk(6'd0, 1'b1, 1'b1, 1'b0, 2,  64'h1E, 64'h13, 1'b1, 1'b0, 1'b0, 4'hB, 5'd2, 1'b0);
      tbl[3]  = mk(6'd0, 1'b1, 1'b1, 1'b0, 1,  64'h7,  64'h7,  1'b1, 1'b0, 1'b0, 4'h7, 5'd1, 1'b0);
      tbl[4]  = mk(6'd2, 1'b0, 1'b0, 1'b0, 2,  64'h13, 64'h13, 1'b1, 1'b0, 1'b0, 4'h2, 5'd2, 1'b0);
      tbl[5]  = mk(6'd2, 1'b0, 1'b0, 1'b1, 2,  64'h13, 64'h13, 1'b1, 1'b0, 1'b0, 4'h3, 5'd2, 1'b0);
      tbl[6]  = mk(6'd0, 1'b0, 1'b0, 1'b0, 16, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111,
                   1'b0, 1'b0, 1'b0, 4'h0, 5'd16, 1'b1);
      tbl[7]  = mk(6'd0, 1'b0, 1'b0, 1'b0, 16, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111,
                   1'b1, 1'b0, 1'b0, 4'h0, 5'd16, 1'b0);
      tbl[8]  = mk(6'd0, 1'b0, 1'b0, 1'b0, 2,  64'h03, 64'h05, 1'b1, 1'b1, 1'b0, 4'hF, 5'd2, 1'b0);
      tbl[9]  = mk(6'd0, 1'b0, 1'b0, 1'b0, 1,  64'h2,  64'h2,  1'b1, 1'b0, 1'b0, 4'h4, 5'd1, 1'b0);
      tbl[10] = mk(6'd0, 1'b0, 1'b0, 1'b0, 1,  64'h3,  64'h5,  1'b1, 1'b0, 1'b1, 4'h0, 5'd0, 1'b0);
      tbl[11] = mk(6'd0, 1'b0, 1'b0, 1'b0, 1,  64'h1,  64'h3,  1'b1, 1'b0, 1'b0, 4'h3, 5'd1, 1'b0);

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_oper = 4'h0; in_coef = 4'h0;
      cfg_out_sel = 6'd0; cfg_sat = 1'b0; cfg_tc = 1'b0; cfg_rnd = 1'b0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {1'b0, all_outs()}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 12; i++) begin
         drive_beats(tbl[i]);
         if (tbl[i].abort) begin
            // In WAIT now: reset discards the pending result.
            rst = 1'b1;
            @(negedge clk);
            chk("abort_reset_outputs", {1'b0, all_outs()}, 32'd0);
            rst = 1'b0;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               chk("abort_no_result", {31'd0, res_valid}, 32'd0);
            end
            chk("abort_ready", {31'd0, in_ready}, 32'd1);
         end else begin
            chk("wait_no_valid", {31'd0, res_valid}, 32'd0);
            @(negedge clk);
            chk("cap_no_valid", {31'd0, res_valid}, 32'd0);
            chk("cap_en_low", {31'd0, mac_en}, 32'd0);
            @(negedge clk);
            chk("res_valid_latency", {31'd0, res_valid}, 32'd1);
            chk("res_data", {28'd0, res_data}, {28'd0, tbl[i].exp_data});
            chk("res_cnt", {27'd0, res_cnt}, {27'd0, tbl[i].exp_cnt});
            chk("res_ovf", {31'd0, res_ovf}, {31'd0, tbl[i].exp_ovf});
            if (tbl[i].hold) begin
               in_valid = 1'b1; in_oper = 4'hA; in_coef = 4'hA;
               for (int k = 0; k < 5; k++) begin
                  @(negedge clk);
                  chk("hold_valid", {31'd0, res_valid}, 32'd1);
                  chk("hold_data", {28'd0, res_data}, {28'd0, tbl[i].exp_data});
                  chk("hold_cnt", {27'd0, res_cnt}, {27'd0, tbl[i].exp_cnt});
                  chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                  chk("hold_en", {31'd0, mac_en}, 32'd0);
                  chk("hold_oper", {28'd0, mac_oper}, {28'd0, tbl[i].op[tbl[i].n - 1]});
               end
               in_valid = 1'b0;
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("accept_valid_low", {31'd0, res_valid}, 32'd0);
            chk("accept_ovf_clear", {31'd0, res_ovf}, 32'd0);
            chk("accept_ready", {31'd0, in_ready}, 32'd1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: ends the run if the sequence above stops making progress.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
